// File: rtl/stream_pkg.sv
// Shared definitions for the stream framer: sample width and framer FSM states.
package stream_pkg;
    localparam int DATA_W = 16;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;
endpackage

// File: rtl/stream_framer_if.sv
// Sample-in / framed-beat-out handshake bundle for the stream framer.
interface stream_framer_if;
    logic [stream_pkg::DATA_W-1:0] idata;
    logic                          ivalid;
    logic                          iready;
    logic [stream_pkg::DATA_W-1:0] odata;
    logic                          ovalid;
    logic                          oready;
    logic                          ostart;
    logic                          olast;

    modport master (
        output idata, ivalid, oready,
        input  iready, odata, ovalid, ostart, olast
    );

    modport slave (
        input  idata, ivalid, oready,
        output iready, odata, ovalid, ostart, olast
    );
endinterface

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO; head word is visible on o_rd_data whenever not empty.
module sync_fifo #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 16
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_wr_en,
    input  logic [DATA_W-1:0]      i_wr_data,
    input  logic                   i_rd_en,
    output logic [DATA_W-1:0]      o_rd_data,
    output logic                   o_full,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_level
);
    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [AW:0]       r_level;
    logic              w_wr;
    logic              w_rd;

    assign o_full    = (r_level == (AW+1)'(DEPTH));
    assign o_empty   = (r_level == '0);
    assign o_level   = r_level;
    assign o_rd_data = r_mem[r_rd_ptr];
    assign w_wr      = i_wr_en && !o_full;
    assign w_rd      = i_rd_en && !o_empty;

    // Storage array, left without reset so it maps onto plain RAM.
    always_ff @(posedge i_clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_wr) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_rd) r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_wr, w_rd})
                2'b10:   r_level <= r_level + (AW+1)'(1);
                2'b01:   r_level <= r_level - (AW+1)'(1);
                default: r_level <= r_level;
            endcase
        end
    end
endmodule

// File: rtl/stream_framer.sv
// Buffers half-precision samples and emits them as frames of flen beats with start/last markers.
module stream_framer
    import stream_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int LEN_W = 8
) (
    input  logic                   aclk,
    input  logic                   areset,
    stream_framer_if.slave         strm,
    input  logic [LEN_W-1:0]       flen,
    output logic [$clog2(DEPTH):0] level
);
    state_t             r_state;
    logic [LEN_W-1:0]   r_cnt;
    logic [LEN_W-1:0]   r_len;
    logic [DATA_W-1:0]  r_odata;
    logic               r_ovalid;
    logic               r_ostart;
    logic               r_olast;

    logic               w_full;
    logic               w_empty;
    logic [DATA_W-1:0]  w_head;
    logic               w_push;
    logic               w_hs;
    logic               w_load;
    logic               w_new_frame;
    logic [LEN_W-1:0]   w_next_idx;
    logic [LEN_W-1:0]   w_flen_eff;

    assign strm.iready = !w_full && !areset;
    assign w_push      = strm.ivalid && strm.iready;
    assign w_hs        = r_ovalid && strm.oready;
    assign w_load      = !w_empty && (!r_ovalid || strm.oready);
    // IDLE always has an empty output register, so either case begins a new frame.
    assign w_new_frame = (r_state == IDLE) || (w_hs && r_olast);
    assign w_next_idx  = r_cnt + LEN_W'(w_hs);
    assign w_flen_eff  = (flen == '0) ? LEN_W'(1) : flen;

    assign strm.odata  = r_odata;
    assign strm.ovalid = r_ovalid;
    assign strm.ostart = r_ostart;
    assign strm.olast  = r_olast;

    sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .i_clk     (aclk),
        .i_rst     (areset),
        .i_wr_en   (w_push),
        .i_wr_data (strm.idata),
        .i_rd_en   (w_load),
        .o_rd_data (w_head),
        .o_full    (w_full),
        .o_empty   (w_empty),
        .o_level   (level)
    );

    // Framer FSM and output register; r_cnt holds the index of the next beat to hand off.
    always_ff @(posedge aclk) begin
        if (areset) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_len    <= '0;
            r_odata  <= '0;
            r_ovalid <= 1'b0;
            r_ostart <= 1'b0;
            r_olast  <= 1'b0;
        end else if (w_load) begin
            r_odata  <= w_head;
            r_ovalid <= 1'b1;
            r_state  <= RUN;
            if (w_new_frame) begin
                r_len    <= w_flen_eff;
                r_cnt    <= '0;
                r_ostart <= 1'b1;
                r_olast  <= (w_flen_eff == LEN_W'(1));
            end else begin
                r_cnt    <= w_next_idx;
                r_ostart <= 1'b0;
                r_olast  <= (w_next_idx == r_len - LEN_W'(1));
            end
        end else if (w_hs) begin
            // Nothing to load: either the frame is done or the FIFO starved mid-frame.
            r_ovalid <= 1'b0;
            if (r_olast) begin
                r_cnt   <= '0;
                r_state <= IDLE;
            end else begin
                r_cnt   <= w_next_idx;
            end
        end else begin
            r_ovalid <= r_ovalid;
        end
    end
endmodule
